id_stage_ctrl: RTL and testbench



---
 rtl/id_stage_ctrl.sv | 155 +++++++++++++++
 tb/tb_id_stage_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_ctrl.sv
// Decode-stage controller: 2-entry skid queue between fetch and execute with immediate generation.
// Define ID_ILLEGAL_CHECK_EN to add the EX_ILLEGAL flag for unrecognised opcodes.
module id_stage_ctrl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IF_VALID,
  output logic        IF_READY,
  input  logic [31:0] IF_INSTRUCTION,
  input  logic [31:0] IF_PC,
  output logic        EX_VALID,
  input  logic        EX_READY,
  output logic [31:0] EX_INSTRUCTION,
  output logic [31:0] EX_PC,
  output logic [31:0] EX_IMMEDIATE,
  output logic [2:0]  EX_IMM_TYPE,
`ifdef ID_ILLEGAL_CHECK_EN
  output logic        EX_ILLEGAL,
`endif
  input  logic        FLUSH
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_e;

  occ_e        occ_q;
  logic        head_q;
  logic        tail_q;
  logic        push;
  logic        pop;

  logic [31:0] instr_q [2];
  logic [31:0] pc_q    [2];
  logic [31:0] imm_q   [2];
  logic [2:0]  type_q  [2];
  logic [34:0] dec_d;

  // Returns {format tag, sign-extended immediate}
  function automatic logic [34:0] decode_imm(input logic [31:0] instr);
    logic [34:0] res;
    case (instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111:
        res = {3'd1, {20{instr[31]}}, instr[31:20]};
      7'b0100011:
        res = {3'd2, {20{instr[31]}}, instr[31:25], instr[11:7]};
      7'b1100011:
        res = {3'd3, {19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        res = {3'd4, instr[31:12], 12'h000};
      7'b1101111:
        res = {3'd5, {11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        res = {3'd0, 32'h0000_0000};
    endcase
    return res;
  endfunction

`ifdef ID_ILLEGAL_CHECK_EN
  logic ill_q [2];

  function automatic logic opcode_illegal(input logic [6:0] opcode);
    logic res;
    case (opcode)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b0110111, 7'b0010111,
      7'b1100011, 7'b1101111, 7'b0110011, 7'b1110011, 7'b0001111: res = 1'b0;
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  assign EX_ILLEGAL = ill_q[head_q];
`endif

  assign IF_READY = (occ_q != ST_FULL);
  assign EX_VALID = (occ_q != ST_EMPTY);
  assign push     = IF_VALID & IF_READY;
  assign pop      = EX_VALID & EX_READY;
  assign dec_d    = decode_imm(IF_INSTRUCTION);

  // Occupancy FSM; flush wins over any simultaneous push or pop
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      occ_q  <= ST_EMPTY;
      head_q <= 1'b0;
      tail_q <= 1'b0;
    end else if (FLUSH) begin
      occ_q  <= ST_EMPTY;
      head_q <= 1'b0;
      tail_q <= 1'b0;
    end else begin
      case (occ_q)
        ST_EMPTY: begin
          if (push) begin
            occ_q  <= ST_ONE;
            tail_q <= ~tail_q;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_q <= ~head_q;
            tail_q <= ~tail_q;
          end else if (push) begin
            occ_q  <= ST_FULL;
            tail_q <= ~tail_q;
          end else if (pop) begin
            occ_q  <= ST_EMPTY;
            head_q <= ~head_q;
          end
        end
        ST_FULL: begin
          if (pop) begin
            occ_q  <= ST_ONE;
            head_q <= ~head_q;
          end
        end
        default: begin
          occ_q  <= ST_EMPTY;
          head_q <= 1'b0;
          tail_q <= 1'b0;
        end
      endcase
    end
  end

  // Entry storage, written at the tail on an accepted push; a flush leaves contents intact
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 2; i++) begin
        instr_q[i] <= 32'h0000_0000;
        pc_q[i]    <= 32'h0000_0000;
        imm_q[i]   <= 32'h0000_0000;
        type_q[i]  <= 3'd0;
`ifdef ID_ILLEGAL_CHECK_EN
        ill_q[i]   <= 1'b0;
`endif
      end
    end else if (push && !FLUSH) begin
      instr_q[tail_q] <= IF_INSTRUCTION;
      pc_q[tail_q]    <= IF_PC;
      imm_q[tail_q]   <= dec_d[31:0];
      type_q[tail_q]  <= dec_d[34:32];
`ifdef ID_ILLEGAL_CHECK_EN
      ill_q[tail_q]   <= opcode_illegal(IF_INSTRUCTION[6:0]);
`endif
    end
  end

  assign EX_INSTRUCTION = instr_q[head_q];
  assign EX_PC          = pc_q[head_q];
  assign EX_IMMEDIATE   = imm_q[head_q];
  assign EX_IMM_TYPE    = type_q[head_q];

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Scoreboard bench for id_stage_ctrl: directed scenarios followed by randomized traffic.
module tb_id_stage_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        IF_VALID = 1'b0;
  logic        IF_READY;
  logic [31:0] IF_INSTRUCTION = 32'h0;
  logic [31:0] IF_PC = 32'h0;
  logic        EX_VALID;
  logic        EX_READY = 1'b0;
  logic [31:0] EX_INSTRUCTION;
  logic [31:0] EX_PC;
  logic [31:0] EX_IMMEDIATE;
  logic [2:0]  EX_IMM_TYPE;
  logic        FLUSH = 1'b0;
`ifdef ID_ILLEGAL_CHECK_EN
  logic        EX_ILLEGAL;
`endif

  id_stage_ctrl dut (
    .CLK(CLK), .RESET(RESET),
    .IF_VALID(IF_VALID), .IF_READY(IF_READY),
    .IF_INSTRUCTION(IF_INSTRUCTION), .IF_PC(IF_PC),
    .EX_VALID(EX_VALID), .EX_READY(EX_READY),
    .EX_INSTRUCTION(EX_INSTRUCTION), .EX_PC(EX_PC),
    .EX_IMMEDIATE(EX_IMMEDIATE), .EX_IMM_TYPE(EX_IMM_TYPE),
`ifdef ID_ILLEGAL_CHECK_EN
    .EX_ILLEGAL(EX_ILLEGAL),
`endif
    .FLUSH(FLUSH)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  typ;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend_e;
  bit   push_pend  = 1'b0;
  bit   flush_pend = 1'b0;
  bit   mon_en     = 1'b0;
  int   errors = 0;
  int   checks = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic int sext(input int v, input int bits);
    int r;
    r = v;
    if (r >= (1 << (bits - 1))) r = r - (1 << bits);
    return r;
  endfunction

  // Reference: RISC-V immediate formats computed with shifts and masks
  function automatic exp_t model(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    int   v;
    int   op;
    int   u;
    u = int'(instr);
    op = u & 127;
    e.instr = instr;
    e.pc = pc;
    e.typ = 3'd0;
    e.imm = 32'h0;
    v = 0;
    if (op == 3 || op == 19 || op == 103) begin
      e.typ = 3'd1;
      v = sext((u >>> 20) & 4095, 12);
    end else if (op == 35) begin
      e.typ = 3'd2;
      v = sext((((u >>> 25) & 127) << 5) | ((u >>> 7) & 31), 12);
    end else if (op == 99) begin
      e.typ = 3'd3;
      v = sext((((u >>> 31) & 1) << 12) | (((u >>> 7) & 1) << 11) |
               (((u >>> 25) & 63) << 5) | (((u >>> 8) & 15) << 1), 13);
    end else if (op == 55 || op == 23) begin
      e.typ = 3'd4;
      v = u & 32'hFFFFF000;
    end else if (op == 111) begin
      e.typ = 3'd5;
      v = sext((((u >>> 31) & 1) << 20) | (((u >>> 12) & 255) << 12) |
               (((u >>> 20) & 1) << 11) | (((u >>> 21) & 1023) << 1), 21);
    end
    e.imm = 32'(v);
    e.ill = !(op == 3 || op == 19 || op == 103 || op == 35 || op == 55 || op == 23 ||
              op == 99 || op == 111 || op == 51 || op == 115 || op == 15);
    return e;
  endfunction

  // One cycle of stimulus; the effect of the previous cycle's push/flush is committed first
  task automatic step(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                      input bit rdy, input bit fl);
    @(posedge CLK);
    #1;
    if (flush_pend) exp_q.delete();
    else if (push_pend) exp_q.push_back(pend_e);
    IF_VALID = v;
    IF_INSTRUCTION = instr;
    IF_PC = pc;
    EX_READY = rdy;
    FLUSH = fl;
    push_pend = v && (exp_q.size() < 2) && !fl;
    flush_pend = fl;
    pend_e = model(instr, pc);
  endtask

  task automatic reset_pulse();
    @(posedge CLK);
    #1;
    if (flush_pend) exp_q.delete();
    else if (push_pend) exp_q.push_back(pend_e);
    check32("pre_reset_valid", {31'b0, EX_VALID}, (exp_q.size() != 0) ? 32'd1 : 32'd0);
    exp_q.delete();
    push_pend = 1'b0;
    flush_pend = 1'b0;
    IF_VALID = 1'b0;
    FLUSH = 1'b0;
    #1 RESET = 1'b1;
    #1;
    check32("rst_ex_valid", {31'b0, EX_VALID}, 32'd0);
    check32("rst_if_ready", {31'b0, IF_READY}, 32'd1);
    check32("rst_instr", EX_INSTRUCTION, 32'd0);
    check32("rst_imm", EX_IMMEDIATE, 32'd0);
    check32("rst_type", {29'b0, EX_IMM_TYPE}, 32'd0);
    RESET = 1'b0;
  endtask

  // Monitor: compares the presented head against the scoreboard and retires it on a pop
  always @(negedge CLK) begin
    if (mon_en && !RESET) begin
      check32("if_ready", {31'b0, IF_READY}, (exp_q.size() < 2) ? 32'd1 : 32'd0);
      check32("ex_valid", {31'b0, EX_VALID}, (exp_q.size() != 0) ? 32'd1 : 32'd0);
      if (exp_q.size() != 0) begin
        check32("ex_instr", EX_INSTRUCTION, exp_q[0].instr);
        check32("ex_pc", EX_PC, exp_q[0].pc);
        check32("ex_imm", EX_IMMEDIATE, exp_q[0].imm);
        check32("ex_type", {29'b0, EX_IMM_TYPE}, {29'b0, exp_q[0].typ});
`ifdef ID_ILLEGAL_CHECK_EN
        check32("ex_illegal", {31'b0, EX_ILLEGAL}, {31'b0, exp_q[0].ill});
`endif
        if (EX_READY && !FLUSH) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [6:0]  ops [12];
    logic [31:0] rnd;
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h33, 7'h73, 7'h0F, 7'h7F};

    #12;
    check32("reset_if_ready", {31'b0, IF_READY}, 32'd1);
    check32("reset_ex_valid", {31'b0, EX_VALID}, 32'd0);
    check32("reset_instr", EX_INSTRUCTION, 32'd0);
    check32("reset_pc", EX_PC, 32'd0);
    check32("reset_imm", EX_IMMEDIATE, 32'd0);
    check32("reset_type", {29'b0, EX_IMM_TYPE}, 32'd0);
`ifdef ID_ILLEGAL_CHECK_EN
    check32("reset_illegal", {31'b0, EX_ILLEGAL}, 32'd0);
`endif
    RESET = 1'b0;
    mon_en = 1'b1;

    step(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check32("addi_valid", {31'b0, EX_VALID}, 32'd1);
    check32("addi_imm", EX_IMMEDIATE, 32'hFFFFFFFF);
    check32("addi_type", {29'b0, EX_IMM_TYPE}, 32'd1);

    step(1'b1, 32'hFE20AC23, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'hFE000EE3, 32'h204, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check32("full_if_ready", {31'b0, IF_READY}, 32'd0);
    check32("sw_imm", EX_IMMEDIATE, 32'hFFFFFFF8);
    check32("sw_type", {29'b0, EX_IMM_TYPE}, 32'd2);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check32("beq_imm", EX_IMMEDIATE, 32'hFFFFFFFC);
    check32("beq_type", {29'b0, EX_IMM_TYPE}, 32'd3);

    step(1'b1, 32'h12345037, 32'h300, 1'b1, 1'b0);
    step(1'b1, 32'h0080006F, 32'h304, 1'b1, 1'b0);
    check32("lui_imm", EX_IMMEDIATE, 32'h12345000);
    check32("lui_type", {29'b0, EX_IMM_TYPE}, 32'd4);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check32("jal_valid", {31'b0, EX_VALID}, 32'd1);
    check32("jal_imm", EX_IMMEDIATE, 32'h00000008);
    check32("jal_type", {29'b0, EX_IMM_TYPE}, 32'd5);

    step(1'b1, 32'h00A00093, 32'h400, 1'b0, 1'b0);
    step(1'b1, 32'h00B00113, 32'h404, 1'b0, 1'b0);
    step(1'b1, 32'h00C00193, 32'h408, 1'b0, 1'b1);
    check32("flush_pre_full", {31'b0, IF_READY}, 32'd0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check32("flush_valid", {31'b0, EX_VALID}, 32'd0);
    check32("flush_if_ready", {31'b0, IF_READY}, 32'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    step(1'b1, 32'h00500113, 32'h500, 1'b0, 1'b0);
    reset_pulse();

`ifdef ID_ILLEGAL_CHECK_EN
    step(1'b1, 32'h0000007F, 32'h600, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check32("ill_flag", {31'b0, EX_ILLEGAL}, 32'd1);
    check32("ill_imm", EX_IMMEDIATE, 32'd0);
    check32("ill_type", {29'b0, EX_IMM_TYPE}, 32'd0);
`endif

    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) begin
        reset_pulse();
      end else begin
        rnd = $urandom;
        rnd[6:0] = ops[$urandom_range(0, 11)];
        if ($urandom_range(0, 9) == 0) rnd[6:0] = 7'($urandom);
        step($urandom_range(0, 3) != 0, rnd, $urandom, $urandom_range(0, 2) != 0,
             $urandom_range(0, 15) == 0);
      end
    end

    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge CLK);
    #1;
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
